// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: one output slot with valid/ready on both sides,
// plus a saturating accepted-op counter. Define ALU_EXEC_OVF_EN to generate signed overflow.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       OpALU,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] OpCount
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [WIDTH-1:0] alu_res;
    logic             slt_bit;
    logic             accept;

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // The slot accepts when empty or when its current content drains on the same edge;
    // ready is forced low while reset is asserted.
    assign in_ready = rst_n & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    assign slt_bit = ($signed(A) < $signed(B));

    always_comb begin
        alu_res = '0;
        case (OpALU)
            OP_NOP: alu_res = '0;
            OP_ADD: alu_res = A + B;
            OP_SUB: alu_res = A - B;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOR: alu_res = ~(A | B);
        endcase
    end

    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;
        if (accept) begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
            if (op_count_q != CNT_MAX) begin
                op_count_d = op_count_q + 1'b1;
            end
        end else if (out_ready) begin
            // Drain without refill: Result keeps its last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

`ifdef ALU_EXEC_OVF_EN
    logic ovf_q, ovf_d, ovf_calc;

    always_comb begin
        ovf_calc = 1'b0;
        case (OpALU)
            OP_ADD:  ovf_calc = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            OP_SUB:  ovf_calc = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            default: ovf_calc = 1'b0;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = ovf_calc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`else
    assign Ovf = 1'b0;
`endif

    assign Result    = result_q;
    assign Zero      = zero_q;
    assign out_valid = out_valid_q;
    assign OpCount   = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: queue-based reference model checked every
// negedge, plus directed vectors with hand-computed literal expectations.
module tb_alu_exec_stage;

    localparam int W      = 32;
    localparam int CW     = 16;
    localparam int CNT_MAX  = 65535;
    localparam int SAT_MAX  = 3;
`ifdef ALU_EXEC_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    OpALU;
    logic [W-1:0]  A, B;
    logic          in_valid, out_ready;
    logic          in_ready, Zero, Ovf, out_valid;
    logic [W-1:0]  Result;
    logic [CW-1:0] OpCount;

    logic          s_in_ready, s_zero, s_ovf, s_out_valid;
    logic [W-1:0]  s_result;
    logic [1:0]    s_opcount;

    alu_exec_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .OpALU(OpALU), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(in_ready), .Result(Result), .Zero(Zero),
        .Ovf(Ovf), .out_valid(out_valid), .out_ready(out_ready), .OpCount(OpCount)
    );

    alu_exec_stage #(.WIDTH(W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .OpALU(OpALU), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(s_in_ready), .Result(s_result), .Zero(s_zero),
        .Ovf(s_ovf), .out_valid(s_out_valid), .out_ready(out_ready), .OpCount(s_opcount)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Packed as {ovf, zero, result}.
    function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [W:0]   wide;
        logic         ov;
        r  = '0;
        ov = 1'b0;
        wide = '0;
        case (op)
            3'd1: begin
                wide = {a[W-1], a} + {b[W-1], b};
                r = wide[W-1:0];
                ov = wide[W] ^ wide[W-1];
            end
            3'd2: begin
                wide = {a[W-1], a} - {b[W-1], b};
                r = wide[W-1:0];
                ov = wide[W] ^ wide[W-1];
            end
            3'd3: begin
                if (a[W-1] != b[W-1]) r = {{(W-1){1'b0}}, a[W-1]};
                else if (a < b)       r = 1;
            end
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            3'd7: r = ~(a | b);
            default: r = '0;
        endcase
        return {ov & OVF_ON, (r == '0), r};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_out = '0;
    int n_acc = 0;

    always @(negedge clk) begin
        logic [W+1:0] cur;
        logic         acc_ok;
        if (!rst_n) begin
            exp_q.delete();
            n_acc = 0;
            last_out = '0;
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_result", {32'd0, Result}, 64'd0);
            chk("rst_opcount", {48'd0, OpCount}, 64'd0);
        end else begin
            acc_ok = (exp_q.size() == 0) || out_ready;
            cur = (exp_q.size() != 0) ? exp_q[0] : last_out;
            chk("in_ready", {63'd0, in_ready}, {63'd0, acc_ok});
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            chk("result", {32'd0, Result}, {32'd0, cur[W-1:0]});
            chk("zero", {63'd0, Zero}, {63'd0, cur[W]});
            chk("ovf", {63'd0, Ovf}, {63'd0, cur[W+1]});
            chk("opcount", {48'd0, OpCount}, 64'(n_acc > CNT_MAX ? CNT_MAX : n_acc));
            chk("sat_opcount", {62'd0, s_opcount}, 64'(n_acc > SAT_MAX ? SAT_MAX : n_acc));
            if (exp_q.size() != 0 && out_ready) last_out = exp_q.pop_front();
            if (in_valid && acc_ok) begin
                exp_q.push_back(model(OpALU, A, B));
                n_acc++;
            end
        end
    end

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        OpALU = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [W-1:0] stream_exp[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        OpALU = '0; A = '0; B = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("lit_reset_zero", {63'd0, Zero}, 64'd0);
        chk("lit_reset_ovf", {63'd0, Ovf}, 64'd0);
        rst_n = 1'b1;

        out_ready = 1'b1;
        issue(3'b001, 32'd5, 32'd7);
        chk("lit_add_result", {32'd0, Result}, 64'd12);
        chk("lit_add_zero", {63'd0, Zero}, 64'd0);
        chk("lit_add_valid", {63'd0, out_valid}, 64'd1);
        chk("lit_add_count", {48'd0, OpCount}, 64'd1);

        issue(3'b010, 32'h1234, 32'h1234);
        chk("lit_sub_result", {32'd0, Result}, 64'd0);
        chk("lit_sub_zero", {63'd0, Zero}, 64'd1);
        issue(3'b011, 32'hFFFF_FFFF, 32'd1);
        chk("lit_slt_neg", {32'd0, Result}, 64'd1);
        issue(3'b011, 32'h7FFF_FFFF, 32'h8000_0000);
        chk("lit_slt_ovf", {32'd0, Result}, 64'd0);

        // Back-pressure: hold the AND result while a pending OR waits.
        issue(3'b100, 32'hF0F0, 32'hFF00);
        chk("lit_and_result", {32'd0, Result}, 64'h0000_F000);
        out_ready = 1'b0;
        OpALU = 3'b101; A = 32'd1; B = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #0;
            chk("lit_hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("lit_hold_result", {32'd0, Result}, 64'h0000_F000);
            chk("lit_hold_valid", {63'd0, out_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_release_result", {32'd0, Result}, 64'd3);

        // Streaming all eight codes from a fresh reset.
        pulse_reset();
        stream_exp = '{32'h0, 32'h16, 32'h2, 32'h0, 32'h8, 32'hE, 32'h6, 32'hFFFF_FFF1};
        for (int i = 0; i < 8; i++) begin
            issue(3'(i), 32'hC, 32'hA);
            chk("lit_stream_result", {32'd0, Result}, {32'd0, stream_exp[i]});
            chk("lit_stream_valid", {63'd0, out_valid}, 64'd1);
        end
        chk("lit_stream_count", {48'd0, OpCount}, 64'd8);
        chk("lit_sat_count", {62'd0, s_opcount}, 64'd3);

        issue(3'b001, 32'h7FFF_FFFF, 32'd1);
        chk("lit_add_ovf_result", {32'd0, Result}, 64'h8000_0000);
        chk("lit_add_ovf", {63'd0, Ovf}, {63'd0, OVF_ON});
        issue(3'b010, 32'h8000_0000, 32'd1);
        chk("lit_sub_ovf_result", {32'd0, Result}, 64'h7FFF_FFFF);
        chk("lit_sub_ovf", {63'd0, Ovf}, {63'd0, OVF_ON});
        issue(3'b100, 32'hFFFF, 32'h00FF);
        chk("lit_and_no_ovf", {63'd0, Ovf}, 64'd0);

        // Asynchronous reset mid-cycle while a result is held.
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_async_valid", {63'd0, out_valid}, 64'd0);
        chk("lit_async_count", {48'd0, OpCount}, 64'd0);
        chk("lit_async_sat", {62'd0, s_opcount}, 64'd0);
        chk("lit_async_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Short mixed run after reset for the per-cycle model.
        for (int i = 0; i < 6; i++) begin
            out_ready = (i % 3) != 2;
            issue(3'(7 - i), 32'h8000_0001 + 32'(i), 32'h0000_00FF << i);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
